timer_avalon_host: RTL and testbench
====================================

Name: timer_avalon_host

Overview:
- Avalon-MM host that drives a 6-register interval-timer responder: status, control, period_l, period_h, snap_l, snap_h.
- Starts the timer in continuous interrupt mode and services each irq by clearing status.
- Counts timeouts and emits a divided "second" strobe for the MP3 playback-time logic.
- Serves on-request counter snapshots. Sits between the timer peripheral and the player control FSM, with no CPU involvement.

Parameters:
- TICK_W, 16: width of tick_count (timeouts serviced since start).
- SEC_DIV, 1: timeouts per sec_pulse; legal range 1..65535.
- PERIOD, 32'h0000C34F: value written to period_l/period_h (used only with the optional feature).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- run  in  1  level; 1 = timer running, 0 = stop timer
- snap_req  in  1  single-cycle request for a counter snapshot
- av_address  out  3  timer register index
- av_chipselect  out  1  timer select
- av_write_n  out  1  active-low write
- av_writedata  out  16  write data
- av_readdata  in  16  timer read data; valid the cycle after address/chipselect are presented
- timer_irq  in  1  timer interrupt, level
- tick  out  1  1-cycle pulse per serviced timeout
- tick_count  out  TICK_W  serviced timeouts since last start; wraps
- sec_pulse  out  1  1-cycle pulse every SEC_DIV ticks
- snap_value  out  32  {snap_h, snap_l}
- snap_valid  out  1  1-cycle pulse when snap_value updates
- busy  out  1  FSM not in IDLE/RUN

Behaviour:
- Reset values:
  - av_chipselect=0, av_write_n=1, av_address=0, av_writedata=0.
  - tick=0, tick_count=0, sec_pulse=0, snap_value=0, snap_valid=0, busy=0.
  - Divider counter = 0; pending snapshot flag = 0; state IDLE.
- Bus rules:
  - The responder has no waitrequest, so every access is exactly one cycle with chipselect=1.
  - Writes: write_n=0. Reads: write_n=1, and data is sampled on the following cycle.
  - chipselect is 0 in every cycle not listed below.
- States and transitions:
  - IDLE: when run=1, go to CFG. busy=0.
  - CFG: write addr1 = 16'h0007 (ITO, CONT, START). Clear tick_count and the divider. Go to RUN.
  - RUN (busy=0):
    - Priority order: run=0 first, then timer_irq=1, then pending snapshot.
    - run=0 -> STOP. timer_irq=1 -> ACK. Pending snapshot -> SNAP_W.
  - ACK:
    - Write addr0 = 0 (clears timeout).
    - Pulse tick and increment tick_count mod 2^TICK_W.
    - Increment the divider. When the divider reaches SEC_DIV-1, pulse sec_pulse and reset the divider to 0.
    - Go to IDLE_WAIT.
  - IDLE_WAIT: one bus-idle cycle so the irq deassert, registered in the responder, is visible. Then go to RUN.
  - SNAP_W: write addr4 = 0 (latches the counter). Go to SNAP_RL.
  - SNAP_RL: read addr4. Go to SNAP_RH.
  - SNAP_RH: read addr5; capture av_readdata into snap_value[15:0]. Go to SNAP_DONE.
  - SNAP_DONE: capture av_readdata into snap_value[31:16]; pulse snap_valid; clear the pending flag. Go to RUN.
  - STOP: write addr1 = 16'h0008 (STOP, ITO=0). Go to IDLE.
- snap_req handling:
  - snap_req in any state sets the pending flag.
  - Multiple requests before service merge into one snapshot.
  - In IDLE, a pending request is held until the next RUN.
- Ordering rules:
  - A snapshot sequence is never interrupted. An irq arriving during it is serviced on return to RUN, because irq is a level that stays asserted.
  - run=0 during ACK or a snapshot sequence takes effect on return to RUN.
- tick_count holds its value through STOP/IDLE and clears only in CFG.
- Reset asserted mid-sequence aborts immediately to reset values. A partially written snapshot is discarded.

Optional Feature:
- Macro: TIMER_AVALON_HOST_PERIOD_WR_EN.
- Defined: CFG becomes three states.
  - Write addr2 = PERIOD[15:0].
  - Write addr3 = PERIOD[31:16].
  - Write addr1 = 16'h0007.
  - This sequence takes 3 cycles from IDLE to RUN.
- Undefined: period registers are never addressed, and CFG is the single control write.

Test Plan:
- Reset then run=1: cycle 1 shows cs=1, wr_n=0, addr=1, wdata=0x0007; next cycle cs=0; tick_count=0.
- Responder model raises irq: one-cycle write addr0 data 0, tick pulse, tick_count 0->1; with SEC_DIV=3, sec_pulse on ticks 3 and 6 only.
- snap_req with model counter=0x1234 at latch: sequence is write addr4, read addr4, read addr5; snap_value=0x00001234 and snap_valid pulses once; two back-to-back snap_req produce one snapshot.
- irq asserted during SNAP_RL: snapshot completes, then ACK follows with no lost tick; tick_count increments by exactly 1.
- run dropped while in RUN: write addr1 data 0x0008, then IDLE; tick_count retained; re-assert run and tick_count=0 after CFG.
- reset_n pulsed low during SNAP_RH: all outputs return to reset values asynchronously; with the macro defined, run=1 gives writes to addr2=0xC34F, addr3=0x0000, addr1=0x0007.

Source files
------------

// File: rtl/timer_avalon_host.sv
`default_nettype none
// ============================================================================
// Module      : timer_avalon_host
// Description : Avalon-MM host for a 6-register interval timer (status,
//               control, period_l, period_h, snap_l, snap_h). It starts the
//               timer in continuous interrupt mode and acknowledges each
//               timeout. It also produces a tick count and a divided
//               "second" strobe, and serves counter snapshots on request.
//               Optional build macro TIMER_AVALON_HOST_PERIOD_WR_EN makes the
//               start-up sequence program period_l/period_h from PERIOD
//               before it writes the control register.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_avalon_host #(
    parameter int          TICK_W  = 16,
    parameter int          SEC_DIV = 1,
    parameter logic [31:0] PERIOD  = 32'h0000C34F
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              run,
    input  logic              snap_req,
    output logic [2:0]        av_address,
    output logic              av_chipselect,
    output logic              av_write_n,
    output logic [15:0]       av_writedata,
    input  logic [15:0]       av_readdata,
    input  logic              timer_irq,
    output logic              tick,
    output logic [TICK_W-1:0] tick_count,
    output logic              sec_pulse,
    output logic [31:0]       snap_value,
    output logic              snap_valid,
    output logic              busy
);

    // Timer register map and control words
    localparam logic [2:0]  c_addr_status   = 3'd0;
    localparam logic [2:0]  c_addr_control  = 3'd1;
    localparam logic [2:0]  c_addr_snap_l   = 3'd4;
    localparam logic [2:0]  c_addr_snap_h   = 3'd5;
    localparam logic [15:0] c_ctrl_start    = 16'h0007;  // ITO | CONT | START
    localparam logic [15:0] c_ctrl_stop     = 16'h0008;  // STOP, ITO cleared
    localparam logic [15:0] c_div_last      = 16'(SEC_DIV - 1);
    localparam logic [15:0] c_div_one       = 16'd1;
    localparam logic [TICK_W-1:0] c_tick_one = TICK_W'(1);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_CFG_PL    = 4'd1,
        S_CFG_PH    = 4'd2,
        S_CFG       = 4'd3,
        S_RUN       = 4'd4,
        S_ACK       = 4'd5,
        S_IDLE_WAIT = 4'd6,
        S_SNAP_W    = 4'd7,
        S_SNAP_RL   = 4'd8,
        S_SNAP_RH   = 4'd9,
        S_SNAP_DONE = 4'd10,
        S_STOP      = 4'd11
    } state_t;

    // One bus cycle worth of host outputs, registered as a unit
    typedef struct packed {
        logic        cs;
        logic        wr_n;
        logic [2:0]  addr;
        logic [15:0] data;
    } bus_t;

    localparam bus_t c_bus_idle = '{cs: 1'b0, wr_n: 1'b1, addr: 3'd0, data: 16'd0};

    function automatic bus_t bus_wr(input logic [2:0] addr, input logic [15:0] data);
        bus_wr = '{cs: 1'b1, wr_n: 1'b0, addr: addr, data: data};
    endfunction

    function automatic bus_t bus_rd(input logic [2:0] addr);
        bus_rd = '{cs: 1'b1, wr_n: 1'b1, addr: addr, data: 16'd0};
    endfunction

    state_t      r_state;
    bus_t        r_bus;
    logic [15:0] r_div;
    logic        r_pending;
    logic [15:0] r_snap_lo;

`ifndef TIMER_AVALON_HOST_PERIOD_WR_EN
    // PERIOD only matters when the period registers are programmed
    logic [31:0] w_unused_period;
    assign w_unused_period = PERIOD;
`endif

    assign av_chipselect = r_bus.cs;
    assign av_write_n    = r_bus.wr_n;
    assign av_address    = r_bus.addr;
    assign av_writedata  = r_bus.data;
    assign busy          = (r_state != S_IDLE) && (r_state != S_RUN);

    // Latch snapshot requests (merging repeats) until the sequence serving them completes;
    // a request in the final sequence cycle survives, because the counter was latched earlier
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending <= 1'b0;
        end else if (snap_req) begin
            r_pending <= 1'b1;
        end else if (r_state == S_SNAP_DONE) begin
            r_pending <= 1'b0;
        end
    end

    // Control FSM. Bus outputs and strobes are registered on the edge that enters
    // a state, so each state's access and pulses are visible during that state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_bus      <= c_bus_idle;
            r_div      <= 16'd0;
            r_snap_lo  <= 16'd0;
            tick       <= 1'b0;
            tick_count <= '0;
            sec_pulse  <= 1'b0;
            snap_value <= 32'd0;
            snap_valid <= 1'b0;
        end else begin
            r_bus      <= c_bus_idle;
            tick       <= 1'b0;
            sec_pulse  <= 1'b0;
            snap_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (run) begin
                        tick_count <= '0;
                        r_div      <= 16'd0;
`ifdef TIMER_AVALON_HOST_PERIOD_WR_EN
                        r_state    <= S_CFG_PL;
                        r_bus      <= bus_wr(3'd2, PERIOD[15:0]);
`else
                        r_state    <= S_CFG;
                        r_bus      <= bus_wr(c_addr_control, c_ctrl_start);
`endif
                    end
                end
`ifdef TIMER_AVALON_HOST_PERIOD_WR_EN
                S_CFG_PL: begin
                    r_state <= S_CFG_PH;
                    r_bus   <= bus_wr(3'd3, PERIOD[31:16]);
                end
                S_CFG_PH: begin
                    r_state <= S_CFG;
                    r_bus   <= bus_wr(c_addr_control, c_ctrl_start);
                end
`endif
                S_CFG: begin
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    if (!run) begin
                        r_state <= S_STOP;
                        r_bus   <= bus_wr(c_addr_control, c_ctrl_stop);
                    end else if (timer_irq) begin
                        r_state    <= S_ACK;
                        r_bus      <= bus_wr(c_addr_status, 16'd0);
                        tick       <= 1'b1;
                        tick_count <= tick_count + c_tick_one;
                        if (r_div == c_div_last) begin
                            sec_pulse <= 1'b1;
                            r_div     <= 16'd0;
                        end else begin
                            r_div <= r_div + c_div_one;
                        end
                    end else if (r_pending) begin
                        r_state <= S_SNAP_W;
                        r_bus   <= bus_wr(c_addr_snap_l, 16'd0);
                    end
                end
                S_ACK: begin
                    // Leave one idle cycle so the responder's registered irq clear is seen
                    r_state <= S_IDLE_WAIT;
                end
                S_IDLE_WAIT: begin
                    r_state <= S_RUN;
                end
                S_SNAP_W: begin
                    r_state <= S_SNAP_RL;
                    r_bus   <= bus_rd(c_addr_snap_l);
                end
                S_SNAP_RL: begin
                    r_state <= S_SNAP_RH;
                    r_bus   <= bus_rd(c_addr_snap_h);
                end
                S_SNAP_RH: begin
                    // Low half is staged so snap_value only ever changes as a whole
                    r_snap_lo <= av_readdata;
                    r_state   <= S_SNAP_DONE;
                end
                S_SNAP_DONE: begin
                    snap_value <= {av_readdata, r_snap_lo};
                    snap_valid <= 1'b1;
                    r_state    <= S_RUN;
                end
                S_STOP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_timer_avalon_host.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer_avalon_host
// Description : Directed bench for timer_avalon_host with a small timer
//               responder model (irq flag, snapshot latch, registered reads).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_avalon_host;

    logic        clk      = 1'b0;
    logic        reset_n  = 1'b0;
    logic        run      = 1'b0;
    logic        snap_req = 1'b0;
    logic [2:0]  av_address;
    logic        av_chipselect;
    logic        av_write_n;
    logic [15:0] av_writedata;
    logic [15:0] av_readdata = 16'hBEEF;
    logic        timer_irq;
    logic        tick;
    logic [15:0] tick_count;
    logic        sec_pulse;
    logic [31:0] snap_value;
    logic        snap_valid;
    logic        busy;

    // Responder model state
    logic        irq_r       = 1'b0;
    logic        to_set      = 1'b0;
    logic [31:0] model_count = 32'd0;
    logic [31:0] snap_latch  = 32'd0;

    int total = 0;
    int bad   = 0;

    // Results of the last observation window
    int          n_acc, n_valid, n_tick, valid_idx, tick_idx;
    logic [31:0] acc [8];
    logic [31:0] valid_val;

    assign timer_irq = irq_r;

    always #5 clk = ~clk;

    timer_avalon_host #(.TICK_W(16), .SEC_DIV(3)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .run           (run),
        .snap_req      (snap_req),
        .av_address    (av_address),
        .av_chipselect (av_chipselect),
        .av_write_n    (av_write_n),
        .av_writedata  (av_writedata),
        .av_readdata   (av_readdata),
        .timer_irq     (timer_irq),
        .tick          (tick),
        .tick_count    (tick_count),
        .sec_pulse     (sec_pulse),
        .snap_value    (snap_value),
        .snap_valid    (snap_valid),
        .busy          (busy)
    );

    // Timer responder: status write clears the timeout, snap_l write latches the counter,
    // reads return data on the following cycle
    always @(posedge clk) begin
        if (av_chipselect && !av_write_n && av_address == 3'd0) irq_r <= 1'b0;
        if (to_set) irq_r <= 1'b1;
        if (av_chipselect && !av_write_n && av_address == 3'd4) snap_latch <= model_count;
        if (av_chipselect && av_write_n) begin
            case (av_address)
                3'd4:    av_readdata <= snap_latch[15:0];
                3'd5:    av_readdata <= snap_latch[31:16];
                default: av_readdata <= 16'hDEAD;
            endcase
        end else begin
            av_readdata <= 16'hBEEF;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "bench timeout");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // {cs, write_n, address} as one word
    function automatic logic [31:0] bus_tag();
        return {27'd0, av_chipselect, av_write_n, av_address};
    endfunction

    // Start-up sequence: assumes run=1 was just applied in IDLE; ends in RUN
    task automatic check_cfg(input string tag);
`ifdef TIMER_AVALON_HOST_PERIOD_WR_EN
        step();
        chk({tag, "_pl_bus"},  bus_tag(), 32'h12);
        chk({tag, "_pl_data"}, 32'(av_writedata), 32'hC34F);
        step();
        chk({tag, "_ph_bus"},  bus_tag(), 32'h13);
        chk({tag, "_ph_data"}, 32'(av_writedata), 32'h0000);
`endif
        step();
        chk({tag, "_ctl_bus"},  bus_tag(), 32'h11);
        chk({tag, "_ctl_data"}, 32'(av_writedata), 32'h0007);
        chk({tag, "_count"},    32'(tick_count), 32'd0);
        chk({tag, "_busy"},     32'(busy), 32'd1);
        step();
        chk({tag, "_cs_off"},   32'(av_chipselect), 32'd0);
        chk({tag, "_idle"},     32'(busy), 32'd0);
    endtask

    // Raise one timeout and check its acknowledge; returns in RUN
    task automatic do_tick(input logic [15:0] exp_cnt, input logic exp_sec);
        bit found;
        found  = 1'b0;
        to_set = 1'b1;
        step();
        to_set = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (tick) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("tick_seen",  32'(found), 32'd1);
        chk("ack_bus",    bus_tag(), 32'h10);
        chk("ack_data",   32'(av_writedata), 32'd0);
        chk("tick_count", 32'(tick_count), 32'(exp_cnt));
        chk("sec_pulse",  32'(sec_pulse), 32'(exp_sec));
        step();
        chk("tick_1cyc",  32'(tick), 32'd0);
        chk("sec_1cyc",   32'(sec_pulse), 32'd0);
        chk("ack_gap",    32'(av_chipselect), 32'd0);
        step();
    endtask

    // Record bus accesses and strobes; snap_req drops after 'hold' cycles
    task automatic observe(input int cycles, input int hold);
        n_acc = 0; n_valid = 0; n_tick = 0;
        valid_idx = -1; tick_idx = -1; valid_val = 32'd0;
        for (int k = 0; k < 8; k++) acc[k] = 32'hFFFF_FFFF;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (i == hold - 1) snap_req = 1'b0;
            if (av_chipselect) begin
                if (n_acc < 8) acc[n_acc] = {28'd0, av_write_n, av_address};
                n_acc++;
            end
            if (snap_valid) begin
                n_valid++;
                valid_idx = i;
                valid_val = snap_value;
            end
            if (tick) begin
                n_tick++;
                tick_idx = i;
            end
        end
    endtask

    task automatic snap_check(input string tag, input logic [31:0] exp);
        chk({tag, "_naccess"}, 32'(n_acc), 32'd3);
        chk({tag, "_w4"},      acc[0], 32'h4);
        chk({tag, "_r4"},      acc[1], 32'hC);
        chk({tag, "_r5"},      acc[2], 32'hD);
        chk({tag, "_nvalid"},  32'(n_valid), 32'd1);
        chk({tag, "_value"},   valid_val, exp);
        chk({tag, "_hold"},    snap_value, exp);
    endtask

    initial begin
        // Reset state
        repeat (3) step();
        chk("rst_cs",    32'(av_chipselect), 32'd0);
        chk("rst_wr_n",  32'(av_write_n), 32'd1);
        chk("rst_addr",  32'(av_address), 32'd0);
        chk("rst_wdata", 32'(av_writedata), 32'd0);
        chk("rst_tick",  32'(tick), 32'd0);
        chk("rst_count", 32'(tick_count), 32'd0);
        chk("rst_sec",   32'(sec_pulse), 32'd0);
        chk("rst_snap",  snap_value, 32'd0);
        chk("rst_valid", 32'(snap_valid), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        reset_n = 1'b1;
        step();
        step();
        chk("idle_quiet", 32'(av_chipselect), 32'd0);

        // Start and six timeouts; with SEC_DIV=3 the strobe lands on ticks 3 and 6
        run = 1'b1;
        check_cfg("cfg1");
        for (int n = 1; n <= 6; n++) do_tick(16'(n), (n % 3) == 0);

        // Back-to-back requests merge; second snapshot exercises the high half
        model_count = 32'h0000_1234;
        snap_req = 1'b1;
        observe(12, 2);
        snap_check("snap_b2b", 32'h0000_1234);
        model_count = 32'hABCD_5678;
        snap_req = 1'b1;
        observe(12, 1);
        snap_check("snap_hi", 32'hABCD_5678);

        // irq raised while the snapshot is in its first read
        model_count = 32'h0000_0042;
        snap_req = 1'b1;
        step();
        snap_req = 1'b0;
        step();
        chk("irqsnap_w4", bus_tag(), 32'h14);
        to_set = 1'b1;
        step();
        to_set = 1'b0;
        chk("irqsnap_r4", bus_tag(), 32'h1C);
        observe(10, 0);
        chk("irqsnap_nacc",  32'(n_acc), 32'd2);
        chk("irqsnap_valid", 32'(n_valid), 32'd1);
        chk("irqsnap_value", valid_val, 32'h0000_0042);
        chk("irqsnap_ntick", 32'(n_tick), 32'd1);
        chk("irqsnap_order", 32'(valid_idx < tick_idx), 32'd1);
        chk("irqsnap_count", 32'(tick_count), 32'd7);

        // Stop, then a request made while idle is served after the restart
        run = 1'b0;
        step();
        chk("stop_bus",  bus_tag(), 32'h11);
        chk("stop_data", 32'(av_writedata), 32'h0008);
        chk("stop_busy", 32'(busy), 32'd1);
        step();
        chk("stop_cs",   32'(av_chipselect), 32'd0);
        chk("stop_idle", 32'(busy), 32'd0);
        snap_req = 1'b1;
        step();
        snap_req = 1'b0;
        repeat (3) step();
        chk("idle_hold_cs",    32'(av_chipselect), 32'd0);
        chk("idle_hold_count", 32'(tick_count), 32'd7);
        model_count = 32'h0BAD_F00D;
        run = 1'b1;
        check_cfg("cfg2");
        observe(12, 0);
        snap_check("snap_held", 32'h0BAD_F00D);
        do_tick(16'd1, 1'b0);

        // Asynchronous reset in the middle of the high-half read
        model_count = 32'h5555_AAAA;
        snap_req = 1'b1;
        step();
        snap_req = 1'b0;
        repeat (3) step();
        chk("rh_bus", bus_tag(), 32'h1D);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_cs",    32'(av_chipselect), 32'd0);
        chk("arst_wr_n",  32'(av_write_n), 32'd1);
        chk("arst_addr",  32'(av_address), 32'd0);
        chk("arst_count", 32'(tick_count), 32'd0);
        chk("arst_snap",  snap_value, 32'd0);
        chk("arst_valid", 32'(snap_valid), 32'd0);
        chk("arst_busy",  32'(busy), 32'd0);
        step();
        reset_n = 1'b1;
        check_cfg("cfg3");
        observe(8, 0);
        chk("arst_no_snap",  32'(n_acc), 32'd0);
        chk("arst_no_valid", 32'(n_valid), 32'd0);
        chk("arst_snap_hold", snap_value, 32'd0);
        do_tick(16'd1, 1'b0);
        do_tick(16'd2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
